// File: rtl/branch_target_unit.sv
// Execute-stage branch/JAL/JALR target resolution plus a direct-mapped BTB with 2-bit counters
// that gives fetch a registered next-PC prediction. Define BTU_RAS_EN to add a return-address stack.
module branch_target_unit #(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [31:0]     upd_ins,
  input  logic [XLEN-1:0] upd_rs1,
  input  logic            upd_cond,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  input  logic            btb_flush,
  output logic            res_valid,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
);
  localparam int IDX  = $clog2(BTB_DEPTH);
  localparam int TAGW = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  typedef enum logic [1:0] {K_BR, K_JMP, K_CALL, K_RET} kind_e;
  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [XLEN-1:0] target;
    kind_e           kind;
  } ent_t;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("XLEN must be 32 or 64");
  end
  if (BTB_DEPTH < 2 || (1 << IDX) != BTB_DEPTH || RAS_DEPTH < 1) begin : g_bad_depth
    $error("BTB_DEPTH must be a power of 2 >= 2 and RAS_DEPTH >= 1");
  end

  // ---------------- decode / resolve ----------------
  logic            is_br, is_jal, is_jalr, is_ctl, taken;
  logic [XLEN-1:0] imm, base, sum, tgt, seq;
  kind_e           ukind;

  assign is_br   = upd_ins[6:0] == 7'b1100011;
  assign is_jal  = upd_ins[6:0] == 7'b1101111;
  assign is_jalr = upd_ins[6:0] == 7'b1100111;
  assign is_ctl  = is_br || is_jal || is_jalr;

  always_comb begin
    imm = {{(XLEN-11){upd_ins[31]}}, upd_ins[30:20]};
    if (is_br)
      imm = {{(XLEN-12){upd_ins[31]}}, upd_ins[7], upd_ins[30:25], upd_ins[11:8], 1'b0};
    else if (is_jal)
      imm = {{(XLEN-20){upd_ins[31]}}, upd_ins[19:12], upd_ins[20], upd_ins[30:21], 1'b0};
  end

  assign base  = is_jalr ? upd_rs1 : upd_pc;
  assign sum   = base + imm;
  assign tgt   = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
  assign seq   = upd_pc + FOUR;
  assign taken = is_br ? upd_cond : 1'b1;

`ifdef BTU_RAS_EN
  logic rd_link, rs1_link, is_call, is_ret;
  assign rd_link  = upd_ins[11:7] == 5'd1 || upd_ins[11:7] == 5'd5;
  assign rs1_link = upd_ins[19:15] == 5'd1 || upd_ins[19:15] == 5'd5;
  assign is_call  = (is_jal || is_jalr) && rd_link;
  assign is_ret   = is_jalr && rs1_link && !rd_link;
  assign ukind    = is_br ? K_BR : is_call ? K_CALL : is_ret ? K_RET : K_JMP;
`else
  assign ukind    = is_br ? K_BR : K_JMP;
`endif

  // ---------------- BTB ----------------
  logic [BTB_DEPTH-1:0]      valid;
  logic [BTB_DEPTH-1:0][1:0] ctr;
  ent_t                      ent [BTB_DEPTH];
  logic [IDX-1:0]            f_idx, u_idx;
  ent_t                      f_ent;
  logic                      f_hit, f_taken, u_hit, upd_en;
  logic [1:0]                u_ctr, ctr_nxt;
  logic [XLEN-1:0]           f_tgt;

  assign f_idx   = fetch_pc[IDX+1:2];
  assign f_ent   = ent[f_idx];
  assign f_hit   = valid[f_idx] && f_ent.tag == fetch_pc[XLEN-1:IDX+2];
  assign f_taken = f_hit && (ctr[f_idx][1] || f_ent.kind != K_BR);

  assign u_idx   = upd_pc[IDX+1:2];
  assign u_hit   = valid[u_idx] && ent[u_idx].tag == upd_pc[XLEN-1:IDX+2];
  assign u_ctr   = ctr[u_idx];
  assign upd_en  = upd_valid && is_ctl && !btb_flush;

  always_comb begin
    ctr_nxt = u_ctr;
    if (taken && u_ctr != 2'd3)       ctr_nxt = u_ctr + 2'd1;
    else if (!taken && u_ctr != 2'd0) ctr_nxt = u_ctr - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      ctr   <= {BTB_DEPTH{2'd1}};
    end else if (btb_flush) begin
      valid <= '0;
    end else if (upd_en) begin
      if (u_hit) begin
        ctr[u_idx] <= ctr_nxt;
      end else if (taken) begin
        valid[u_idx] <= 1'b1;
        ctr[u_idx]   <= is_br ? 2'd2 : 2'd3;
      end
    end
  end

  // Payload needs no reset: it is only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (upd_en && taken)
      ent[u_idx] <= '{tag: upd_pc[XLEN-1:IDX+2], target: tgt, kind: ukind};
  end

`ifdef BTU_RAS_EN
  // ---------------- return-address stack (circular, oldest overwritten) ----------------
  localparam int RW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [RW-1:0]   ras_ptr, ras_top_ptr, ras_nxt_ptr;
  logic [CW-1:0]   ras_cnt;
  logic            ras_push, ras_pop;

  assign ras_top_ptr = (ras_ptr == '0) ? RW'(RAS_DEPTH-1) : ras_ptr - RW'(1);
  assign ras_nxt_ptr = (ras_ptr == RW'(RAS_DEPTH-1)) ? '0 : ras_ptr + RW'(1);
  assign ras_push    = upd_valid && is_call;
  assign ras_pop     = upd_valid && is_ret && ras_cnt != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_ptr <= ras_nxt_ptr;
      if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + CW'(1);
    end else if (ras_pop) begin
      ras_ptr <= ras_top_ptr;
      ras_cnt <= ras_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) ras[ras_ptr] <= seq;
  end
`endif

  always_comb begin
    f_tgt = fetch_pc + FOUR;
    if (f_taken) begin
      f_tgt = f_ent.target;
`ifdef BTU_RAS_EN
      if (f_ent.kind == K_RET && ras_cnt != '0) f_tgt = ras[ras_top_ptr];
`endif
    end
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      res_valid   <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      pred_valid <= fetch_valid;
      if (fetch_valid) begin
        pred_taken  <= f_taken;
        pred_target <= f_tgt;
      end
      res_valid  <= upd_valid && is_ctl;
      mispredict <= 1'b0;
      if (upd_valid && is_ctl) begin
        mispredict  <= (taken != upd_pred_taken) || (taken && tgt != upd_pred_target);
        redirect_pc <= taken ? tgt : seq;
      end
    end
  end
endmodule
